// File: rtl/uart_pkg.sv
// Shared encodings and frame constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } uart_state_e;

  localparam int UART_DATA_W = 8;

  // Line levels of the framing bits.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // bit_done is the final cycle of the current period; the counter wraps then.
  assign bit_done = en && (cnt == LAST);

  // Period counter; clear has priority so a new frame always starts at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= bit_done ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time and sends it as a UART 8N1 frame.
// Outputs are registered from the next-state values, so tx/busy line up with
// the state they describe while fifo_rd is visible during FETCH; the FIFO then
// presents data in LOAD, where it is captured.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = UART_DATA_W,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy
);

  localparam int              IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              cnt_clr, cnt_en, bit_done;
  logic              fifo_rd_d, tx_d, busy_d;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .bit_done (bit_done)
  );

  // Next-state, shift register and bit index.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    fifo_rd_d = 1'b0;
    case (state_q)
      IDLE: begin
        // tx_en and fifo_empty only matter here; mid-frame they are ignored.
        if (tx_en && !fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        shift_d   = fifo_data;
        bit_idx_d = '0;
        cnt_clr   = 1'b1;
        state_d   = START;
      end
      START: begin
        cnt_en = 1'b1;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        cnt_en = 1'b1;
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the cycle the next state occupies.
  always_comb begin
    tx_d   = STOP_BIT;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      default: tx_d = STOP_BIT;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Registered outputs; reset drives the line idle at once, even mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_rd <= 1'b0;
      tx      <= STOP_BIT;
      busy    <= 1'b0;
    end else begin
      fifo_rd <= fifo_rd_d;
      tx      <= tx_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with a behavioural FIFO, a frame-decoding monitor
// and a scoreboard of expected bytes.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_en = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd, tx, busy;

  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int         rd_times[$];
  int         cyc = 0, last_rd = 0, rst_events = 0;
  int         wr_total = 0, underflow = 0;
  int         n_cmp = 0, n_err = 0;
  logic       prev_rd = 1'b0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge rst) rst_events = rst_events + 1;

  // Behavioural FIFO: data_out registered on the pop, empty flag registered.
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (fq.size() == 0) underflow = underflow + 1;
      else fifo_data <= fq.pop_front();
    end
    if (wr_req) begin
      fq.push_back(wr_data);
      wr_total = wr_total + 1;
    end
    fifo_empty <= (fq.size() == 0);
  end

  task automatic check_eq(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; one write lands on the following posedge.
  task automatic write_byte(input logic [7:0] b, input bit expect_tx);
    wr_req  = 1'b1;
    wr_data = b;
    if (expect_tx) exp_q.push_back(b);
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic wait_rd(input string name);
    int t = 0;
    while (!fifo_rd && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq(name, int'(fifo_rd), 1);
  endtask

  task automatic wait_quiet(input string name);
    int t = 0;
    while (!(busy == 1'b0 && fifo_empty && exp_q.size() == 0 && !fifo_rd) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq(name, int'(t < 2000), 1);
    repeat (3) @(negedge clk);
  endtask

  // fifo_rd monitor: single-cycle pulses, never while empty.
  initial begin
    @(posedge rst);
    forever begin
      @(negedge clk);
      if (rst && fifo_rd) begin
        check_eq("fifo_rd_width", int'(prev_rd), 0);
        check_eq("rd_while_empty", int'(fifo_empty), 0);
        rd_times.push_back(cyc);
        last_rd = cyc;
      end
      prev_rd = fifo_rd;
    end
  end

  // Frame decoder: samples the second cycle of each bit; abandons a frame if
  // reset hits during it.
  initial begin
    int         k, ev;
    bit         ok;
    logic       st, sp;
    logic [7:0] b;
    @(posedge rst);
    forever begin
      @(negedge clk);
      if (rst && tx == 1'b0) begin
        k  = cyc;
        ev = rst_events;
        ok = 1'b1;
        st = 1'b1;
        sp = 1'b0;
        b  = 8'h00;
        check_eq("start_latency", k - last_rd, 2);
        for (int c = 1; c <= 37 && ok; c++) begin
          @(negedge clk);
          if (ev != rst_events) ok = 1'b0;
          else if (c == 1) st = tx;
          else if (c >= 5 && c <= 33 && ((c - 5) % 4) == 0) b[(c - 5) / 4] = tx;
          else if (c == 37) sp = tx;
        end
        if (ok) begin
          check_eq("start_bit", int'(st), 0);
          check_eq("stop_bit", int'(sp), 1);
          if (exp_q.size() == 0) check_eq("unexpected_frame", int'(b), -1);
          else check_eq("frame_byte", int'(b), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // Busy length per frame (frames cut by reset are skipped).
  initial begin
    int len = 0, ev0 = 0;
    @(posedge rst);
    forever begin
      @(negedge clk);
      if (busy) begin
        if (len == 0) ev0 = rst_events;
        len++;
      end else if (len > 0) begin
        if (ev0 == rst_events) check_eq("busy_length", len, 10 * CPB + 2);
        len = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, busy_hi;

    // Reset: outputs idle immediately and after two cycles.
    #1 rst = 1'b0;
    #1;
    check_eq("reset_tx_async", int'(tx), 1);
    check_eq("reset_busy_async", int'(busy), 0);
    repeat (2) @(negedge clk);
    check_eq("reset_tx", int'(tx), 1);
    check_eq("reset_fifo_rd", int'(fifo_rd), 0);
    check_eq("reset_busy", int'(busy), 0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check_eq("no_rd_when_empty", rd_times.size(), 0);

    // Single byte 0x11.
    write_byte(8'h11, 1'b1);
    wait_quiet("single_done");
    check_eq("single_rd_count", rd_times.size(), 1);

    // Back-to-back bytes, fifo_rd pulses 43 cycles apart.
    n0 = rd_times.size();
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    write_byte(8'h44, 1'b1);
    wait_quiet("b2b_done");
    check_eq("b2b_rd_count", rd_times.size() - n0, 4);
    for (int i = 1; i < 4; i++)
      if (rd_times.size() >= n0 + 4)
        check_eq("b2b_spacing", rd_times[n0 + i] - rd_times[n0 + i - 1], 10 * CPB + 3);
    check_eq("b2b_fifo_empty", int'(fifo_empty), 1);

    // tx_en dropped mid-frame: 0x22 completes, 0x33 waits.
    n0 = rd_times.size();
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    wait_rd("txen_first_rd");
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (!busy) break;
    end
    repeat (100) @(negedge clk);
    check_eq("txen_held_rd_count", rd_times.size() - n0, 1);
    check_eq("txen_pending_frames", exp_q.size(), 1);
    check_eq("txen_fifo_not_empty", int'(fifo_empty), 0);
    tx_en = 1'b1;
    wait_quiet("txen_resume_done");
    check_eq("txen_rd_count", rd_times.size() - n0, 2);

    // Reset during bit 4 of 0xA5; only 0x5A must appear afterwards.
    n0 = rd_times.size();
    write_byte(8'hA5, 1'b0);
    write_byte(8'h5A, 1'b1);
    wait_rd("rst_first_rd");
    repeat (23) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midframe_rst_tx", int'(tx), 1);
    check_eq("midframe_rst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_quiet("post_rst_done");
    check_eq("post_rst_rd_count", rd_times.size() - n0, 2);

    // Empty edge: stays idle, reads match writes, no underflow.
    busy_hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || fifo_rd) busy_hi++;
    end
    check_eq("final_idle", busy_hi, 0);
    check_eq("final_tx_high", int'(tx), 1);
    check_eq("final_fifo_empty", int'(fifo_empty), 1);
    check_eq("reads_eq_writes", rd_times.size(), wr_total);
    check_eq("underflow", underflow, 0);
    check_eq("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
